// File: rtl/esplink_apb_arb.sv
// rtl/esplink_apb_arb.sv - round-robin APB arbiter sharing one slave port, with transfer watchdog
module esplink_apb_arb #(
    parameter int NMST    = 2,
    parameter int APB_DW  = 32,
    parameter int APB_AW  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [NMST-1:0]          m_psel,
    input  logic [NMST-1:0]          m_penable,
    input  logic [NMST-1:0]          m_pwrite,
    input  logic [NMST*APB_AW-1:0]   m_paddr,
    input  logic [NMST*APB_DW-1:0]   m_pwdata,
    output logic [NMST-1:0]          m_pready,
    output logic [NMST-1:0]          m_pslverr,
    output logic [APB_DW-1:0]        m_prdata,
    output logic                     s_psel,
    output logic                     s_penable,
    output logic                     s_pwrite,
    output logic [APB_AW-1:0]        s_paddr,
    output logic [APB_DW-1:0]        s_pwdata,
    input  logic                     s_pready,
    input  logic                     s_pslverr,
    input  logic [APB_DW-1:0]        s_prdata,
    output logic                     busy,
    output logic [$clog2(NMST)-1:0]  gnt
);

    localparam int GW = $clog2(NMST);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t         state;
    logic [GW-1:0]  last_gnt;
    logic [GW-1:0]  nxt;
    logic           found;
    logic [CW-1:0]  wcnt;
    logic           timeout_hit;
    logic           xfer_done;
    logic           unused_penable;

    // Masters follow APB on their own; penable carries no information the arbiter needs.
    assign unused_penable = ^m_penable;

    // Winner is the requester at the smallest rotational distance past last_gnt.
    always_comb begin
        int best_d;
        int d;
        nxt    = '0;
        found  = |m_psel;
        best_d = NMST;
        d      = 0;
        for (int i = 0; i < NMST; i++) begin
            if (m_psel[i]) begin
                d = (i + NMST - 1 - int'(last_gnt)) % NMST;
                if (d < best_d) begin
                    best_d = d;
                    nxt    = GW'(i);
                end
            end
        end
    end

    assign timeout_hit = (TIMEOUT != 0) && (wcnt == CW'(TIMEOUT));
    assign xfer_done   = (state == ACCESS) && (s_pready || timeout_hit);

    // A master that abandoned its request mid-transfer gets no completion pulse.
    always_comb begin
        m_pready  = '0;
        m_pslverr = '0;
        m_prdata  = '0;
        if (xfer_done && m_psel[gnt]) begin
            m_pready[gnt]  = 1'b1;
            m_pslverr[gnt] = s_pready ? s_pslverr : 1'b1;
            if (s_pready) begin
                m_prdata = s_prdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            s_psel    <= 1'b0;
            s_penable <= 1'b0;
            s_pwrite  <= 1'b0;
            s_paddr   <= '0;
            s_pwdata  <= '0;
            busy      <= 1'b0;
            gnt       <= '0;
            last_gnt  <= GW'(NMST - 1);
            wcnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        gnt      <= nxt;
                        last_gnt <= nxt;
                        s_paddr  <= m_paddr[int'(nxt)*APB_AW +: APB_AW];
                        s_pwdata <= m_pwdata[int'(nxt)*APB_DW +: APB_DW];
                        s_pwrite <= m_pwrite[nxt];
                        s_psel   <= 1'b1;
                        busy     <= 1'b1;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    s_penable <= 1'b1;
                    wcnt      <= '0;
                    state     <= ACCESS;
                end
                ACCESS: begin
                    if (xfer_done) begin
                        s_psel    <= 1'b0;
                        s_penable <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else if (wcnt != '1) begin
                        wcnt <= wcnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_esplink_apb_arb.sv
// tb/tb_esplink_apb_arb.sv - self-checking bench for esplink_apb_arb
module tb_esplink_apb_arb;

    logic        clk = 1'b0;
    logic        rstn;
    logic [1:0]  m_psel, m_penable, m_pwrite;
    logic [63:0] m_paddr, m_pwdata;
    logic [1:0]  m_pready, m_pslverr, to_pready, to_pslverr;
    logic [31:0] m_prdata, to_prdata;
    logic        s_psel, s_penable, s_pwrite, to_psel, to_penable, to_pwrite;
    logic [31:0] s_paddr, s_pwdata, to_paddr, to_pwdata;
    logic        s_pready, s_pslverr;
    logic [31:0] s_prdata, tb_prdata;
    logic        slave_auto;
    logic        busy, to_busy;
    logic        gnt, to_gnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign s_prdata = slave_auto ? {16'hBEEF, s_paddr[15:0]} : tb_prdata;

    esplink_apb_arb #(.NMST(2), .APB_DW(32), .APB_AW(32), .TIMEOUT(255)) dut (
        .clk(clk), .rstn(rstn),
        .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
        .m_paddr(m_paddr), .m_pwdata(m_pwdata),
        .m_pready(m_pready), .m_pslverr(m_pslverr), .m_prdata(m_prdata),
        .s_psel(s_psel), .s_penable(s_penable), .s_pwrite(s_pwrite),
        .s_paddr(s_paddr), .s_pwdata(s_pwdata),
        .s_pready(s_pready), .s_pslverr(s_pslverr), .s_prdata(s_prdata),
        .busy(busy), .gnt(gnt)
    );

    esplink_apb_arb #(.NMST(2), .APB_DW(32), .APB_AW(32), .TIMEOUT(4)) dut_to (
        .clk(clk), .rstn(rstn),
        .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
        .m_paddr(m_paddr), .m_pwdata(m_pwdata),
        .m_pready(to_pready), .m_pslverr(to_pslverr), .m_prdata(to_prdata),
        .s_psel(to_psel), .s_penable(to_penable), .s_pwrite(to_pwrite),
        .s_paddr(to_paddr), .s_pwdata(to_pwdata),
        .s_pready(s_pready), .s_pslverr(s_pslverr), .s_prdata(s_prdata),
        .busy(to_busy), .gnt(to_gnt)
    );

    typedef struct {
        logic [1:0]  psel, pwrite;
        logic        spr, serr;
        logic [31:0] sprd;
        logic        e_spsel, e_spen, e_busy;
        logic [1:0]  e_prdy, e_perr;
        logic [31:0] e_prd;
        logic        e_gnt, e_swr;
        logic [31:0] e_addr, e_wdata;
    } vec_t;

    typedef struct {
        int          mst;
        logic [31:0] rd;
        logic        err;
    } exp_t;

    vec_t vec[12];
    exp_t sbq[$];

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic do_reset();
        rstn       = 1'b0;
        m_psel     = 2'b00;
        m_pwrite   = 2'b00;
        s_pready   = 1'b0;
        s_pslverr  = 1'b0;
        tb_prdata  = 32'h0;
        slave_auto = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        exp_t e;
        int   ndone, last_c, pulses;

        m_penable  = 2'b00;
        m_paddr    = {32'h0000_0000, 32'h0000_0004};
        m_pwdata   = {32'h0000_0001, 32'h0000_00A5};
        rstn       = 1'b0;
        m_psel     = 2'b00;
        m_pwrite   = 2'b00;
        s_pready   = 1'b0;
        s_pslverr  = 1'b0;
        tb_prdata  = 32'h0;
        slave_auto = 1'b0;

        //            psel  pwr   spr   serr  sprd    spsel spen busy prdy  perr  prd     gnt   swr   addr   wdata
        vec[0]  = '{2'b01,2'b00,1'b1,1'b0,32'h1,  1'b0,1'b0,1'b0,2'b00,2'b00,32'h0, 1'b0,1'b0,32'h0,32'h0};
        vec[1]  = '{2'b01,2'b00,1'b1,1'b0,32'h1,  1'b1,1'b0,1'b1,2'b00,2'b00,32'h0, 1'b0,1'b0,32'h4,32'hA5};
        vec[2]  = '{2'b01,2'b00,1'b1,1'b0,32'h1,  1'b1,1'b1,1'b1,2'b01,2'b00,32'h1, 1'b0,1'b0,32'h4,32'hA5};
        vec[3]  = '{2'b00,2'b00,1'b1,1'b0,32'h1,  1'b0,1'b0,1'b0,2'b00,2'b00,32'h0, 1'b0,1'b0,32'h0,32'h0};
        vec[4]  = '{2'b10,2'b10,1'b1,1'b0,32'h0,  1'b0,1'b0,1'b0,2'b00,2'b00,32'h0, 1'b0,1'b0,32'h0,32'h0};
        vec[5]  = '{2'b10,2'b10,1'b1,1'b0,32'h0,  1'b1,1'b0,1'b1,2'b00,2'b00,32'h0, 1'b1,1'b1,32'h0,32'h1};
        vec[6]  = '{2'b10,2'b10,1'b1,1'b0,32'h0,  1'b1,1'b1,1'b1,2'b10,2'b00,32'h0, 1'b1,1'b1,32'h0,32'h1};
        vec[7]  = '{2'b00,2'b00,1'b1,1'b0,32'h0,  1'b0,1'b0,1'b0,2'b00,2'b00,32'h0, 1'b1,1'b0,32'h0,32'h0};
        vec[8]  = '{2'b01,2'b00,1'b1,1'b1,32'h55, 1'b0,1'b0,1'b0,2'b00,2'b00,32'h0, 1'b1,1'b0,32'h0,32'h0};
        vec[9]  = '{2'b01,2'b00,1'b1,1'b1,32'h55, 1'b1,1'b0,1'b1,2'b00,2'b00,32'h0, 1'b0,1'b0,32'h4,32'hA5};
        vec[10] = '{2'b01,2'b00,1'b1,1'b1,32'h55, 1'b1,1'b1,1'b1,2'b01,2'b01,32'h55,1'b0,1'b0,32'h4,32'hA5};
        vec[11] = '{2'b00,2'b00,1'b1,1'b0,32'h0,  1'b0,1'b0,1'b0,2'b00,2'b00,32'h0, 1'b0,1'b0,32'h0,32'h0};

        #2;
        chk("rst_spsel", 0, s_psel, 0);
        chk("rst_spen", 0, s_penable, 0);
        chk("rst_busy", 0, busy, 0);
        chk("rst_gnt", 0, gnt, 0);
        chk("rst_pready", 0, m_pready, 0);
        chk("rst_prdata", 0, m_prdata, 0);

        do_reset();
        for (int i = 0; i < 12; i++) begin
            m_psel    = vec[i].psel;
            m_pwrite  = vec[i].pwrite;
            s_pready  = vec[i].spr;
            s_pslverr = vec[i].serr;
            tb_prdata = vec[i].sprd;
            @(negedge clk);
            chk("vec_spsel", i, s_psel, vec[i].e_spsel);
            chk("vec_spen", i, s_penable, vec[i].e_spen);
            chk("vec_busy", i, busy, vec[i].e_busy);
            chk("vec_pready", i, m_pready, vec[i].e_prdy);
            chk("vec_pslverr", i, m_pslverr, vec[i].e_perr);
            chk("vec_prdata", i, m_prdata, vec[i].e_prd);
            chk("vec_gnt", i, gnt, vec[i].e_gnt);
            if (vec[i].e_spsel) begin
                chk("vec_spwrite", i, s_pwrite, vec[i].e_swr);
                chk("vec_spaddr", i, s_paddr, vec[i].e_addr);
                chk("vec_spwdata", i, s_pwdata, vec[i].e_wdata);
            end
            @(posedge clk);
            #1;
        end

        // contention: both masters request continuously from reset
        do_reset();
        slave_auto = 1'b1;
        s_pready   = 1'b1;
        m_psel     = 2'b11;
        sbq.push_back('{0, 32'hBEEF0004, 1'b0});
        sbq.push_back('{1, 32'hBEEF0000, 1'b0});
        sbq.push_back('{0, 32'hBEEF0004, 1'b0});
        sbq.push_back('{1, 32'hBEEF0000, 1'b0});
        ndone  = 0;
        last_c = -1;
        for (int c = 0; c < 40 && ndone < 4; c++) begin
            @(negedge clk);
            if (m_pready != 2'b00) begin
                if (sbq.size() == 0) begin
                    chk("rr_underflow", c, 1, 0);
                end else begin
                    e = sbq.pop_front();
                    chk("rr_pready", ndone, m_pready, 32'(1) << e.mst);
                    chk("rr_prdata", ndone, m_prdata, e.rd);
                    chk("rr_pslverr", ndone, m_pslverr, 0);
                    chk("rr_spacing", ndone, c - last_c, 3);
                end
                last_c = c;
                ndone++;
                if (ndone == 4) m_psel = 2'b00;
            end
            @(posedge clk);
            #1;
        end
        chk("rr_count", 0, ndone, 4);
        chk("rr_sb_empty", 0, sbq.size(), 0);
        @(negedge clk);
        chk("rr_idle_busy", 0, busy, 0);

        // wait states: five s_pready=0 cycles then an error completion
        do_reset();
        tb_prdata = 32'h77;
        s_pslverr = 1'b1;
        pulses    = 0;
        for (int c = 0; c < 10; c++) begin
            s_pready = (c == 7);
            m_psel   = (c <= 7) ? 2'b01 : 2'b00;
            @(negedge clk);
            if (c >= 2 && c <= 7) chk("ws_penable", c, s_penable, 1);
            if (m_pready[0]) pulses++;
            if (c == 7) begin
                chk("ws_pready", c, m_pready, 2'b01);
                chk("ws_pslverr", c, m_pslverr, 2'b01);
                chk("ws_prdata", c, m_prdata, 32'h77);
            end
            @(posedge clk);
            #1;
        end
        chk("ws_pulses", 0, pulses, 1);

        // timeout: TIMEOUT=4 instance with the slave stuck
        do_reset();
        tb_prdata = 32'hDEAD;
        for (int c = 0; c < 10; c++) begin
            m_psel = (c >= 7) ? 2'b10 : 2'b11;
            @(negedge clk);
            chk("to_pready", c, to_pready, (c == 6) ? 2'b01 : 2'b00);
            if (c == 6) begin
                chk("to_pslverr", c, to_pslverr, 2'b01);
                chk("to_prdata", c, to_prdata, 0);
                chk("to_no_early_255", c, m_pready, 0);
            end
            if (c == 7) chk("to_spsel_drop", c, to_psel, 0);
            if (c == 8) begin
                chk("to_next_gnt", c, to_gnt, 1);
                chk("to_next_spsel", c, to_psel, 1);
            end
            @(posedge clk);
            #1;
        end

        // asynchronous reset in ACCESS
        do_reset();
        m_psel = 2'b01;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 s_pready = 1'b1;
        @(negedge clk);
        chk("ar_pre_spen", 0, s_penable, 1);
        chk("ar_pre_pready", 0, m_pready, 2'b01);
        #2 rstn = 1'b0;
        #1;
        chk("ar_spsel", 0, s_psel, 0);
        chk("ar_spen", 0, s_penable, 0);
        chk("ar_busy", 0, busy, 0);
        chk("ar_pready", 0, m_pready, 0);
        m_psel = 2'b11;
        @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("ar_gnt_after", 0, gnt, 0);
        chk("ar_spsel_after", 0, s_psel, 1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("ar_pready_after", 0, m_pready, 2'b01);
        m_psel = 2'b00;
        @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
